sm_reg_scanner: RTL and testbench
=================================

Name: sm_reg_scanner

Overview:
- Controller that sequences the CPU register-file debug read port (regAddr/regData) for the board-level display path.
- Auto mode: steps through a programmable address window, holds each register for a dwell period, and captures the value into a stable display register.
- Manual mode: tracks a switch-selected address and refreshes it periodically.
- Sits between board switches/keys and sm_cpu's debug port. Runs on the 50 MHz board clock, independent of the divided CPU clock.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- DWELL_W, 26, dwell counter width.
- SETTLE, 2, cycles between regAddr change and capture; legal range 1..15.

Ports:
- clk  input  1  board clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = manual, 1 = auto scan.
- pause  input  1  freezes dwell counting (no advance, no refresh).
- manualAddr  input  ADDR_W  address used in manual mode.
- firstAddr  input  ADDR_W  auto window start.
- lastAddr  input  ADDR_W  auto window end, inclusive.
- dwellLimit  input  DWELL_W  dwell length in cycles; 0 treated as 1.
- regAddr  output  ADDR_W  registered address to CPU debug port.
- regData  input  DATA_W  combinational read data from CPU.
- dispAddr  output  ADDR_W  address of last captured value.
- dispData  output  DATA_W  last captured value.
- dispValid  output  1  high once the first capture is done.
- wrapPulse  output  1  one-cycle pulse when auto scan wraps.

Behaviour:
- Reset (async, rst_n=0): regAddr=0, dispAddr=0, dispData=0, dispValid=0, wrapPulse=0, state=LOAD, settle and dwell counters=0.
- States: LOAD, SETUP, DWELL. All outputs are registered.
- LOAD: one cycle.
  - regAddr <= (mode ? firstAddr : manualAddr); settle counter cleared; next state SETUP.
- SETUP: regAddr held for exactly SETTLE cycles. The settle counter counts 0..SETTLE-1.
  - On the edge that leaves SETUP: dispData<=regData, dispAddr<=regAddr, dispValid<=1, dwell counter cleared, next state DWELL.
  - Latency: dispData updates SETTLE edges after the regAddr-change edge.
  - mode, manualAddr and pause are ignored in SETUP.
- DWELL: evaluated each cycle in priority order:
  - 1. Manual mode (mode=0) and manualAddr != regAddr: regAddr<=manualAddr, go to SETUP immediately, regardless of pause or dwell count.
  - 2. mode differs from the mode latched at the last LOAD/advance: go to LOAD.
  - 3. pause=1: hold dwell counter; no other action.
  - 4. Dwell counter reaches max(dwellLimit,1)-1: dwell expiry (below).
  - 5. Otherwise: dwell counter increments.
- Dwell expiry:
  - Manual: regAddr unchanged, go to SETUP (refresh).
  - Auto:
    - If regAddr==lastAddr or regAddr outside [firstAddr,lastAddr]: regAddr<=firstAddr, and wrapPulse=1 for exactly one cycle if regAddr==lastAddr.
    - Otherwise regAddr<=regAddr+1. Go to SETUP.
- Auto period per address = SETTLE + max(dwellLimit,1) cycles.
- firstAddr > lastAddr: the window degenerates to firstAddr only. Every expiry reloads firstAddr; wrapPulse is never asserted.
- firstAddr == lastAddr: a single address; wrapPulse fires on every expiry.
- Address arithmetic is ADDR_W bits. lastAddr=31 wraps to firstAddr, never to 0 via overflow.
- dispData/dispAddr change only on SETUP exit and are otherwise stable; dispValid never drops except on reset.
- Reset mid-scan: immediate return to reset values; scanning restarts from LOAD after rst_n deasserts.
- wrapPulse is 0 in every cycle except the expiry-wrap edge above.

Test Plan:
- Reset, then mode=1, firstAddr=2, lastAddr=4, dwellLimit=3, SETTLE=2, regData=addr*16 → regAddr sequence 2,3,4,2 with 5 cycles each; dispData 0x20,0x30,0x40; wrapPulse one cycle when 4→2.
- mode=0, manualAddr=7, dwellLimit=10, regData changed mid-dwell 0x11→0x22 → dispData 0x11, then 0x22 after the refresh (SETTLE edges after SETUP entry); regAddr stays 7.
- Manual, change manualAddr 7→9 mid-dwell with pause=1 → regAddr=9 next edge; dispAddr=9 two edges later.
- Auto with pause=1 for 50 cycles during DWELL → regAddr, dispData constant and no wrapPulse; on release, advance occurs after the remaining dwell count.
- firstAddr=6, lastAddr=3 (inverted) and dwellLimit=0 → regAddr constant at 6, period 3 cycles, wrapPulse never asserted.
- Assert rst_n=0 mid-SETUP, then release → all outputs 0 and dispValid=0; first capture occurs SETTLE+1 cycles after release.

Source files
------------

// File: rtl/sm_reg_scanner.sv
// Sequences the CPU register-file debug read port and latches a stable copy
// of the selected register for the board display path.
module sm_reg_scanner #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int DWELL_W = 26,
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               pause,
  input  logic [ADDR_W-1:0]  manualAddr,
  input  logic [ADDR_W-1:0]  firstAddr,
  input  logic [ADDR_W-1:0]  lastAddr,
  input  logic [DWELL_W-1:0] dwellLimit,
  output logic [ADDR_W-1:0]  regAddr,
  input  logic [DATA_W-1:0]  regData,
  output logic [ADDR_W-1:0]  dispAddr,
  output logic [DATA_W-1:0]  dispData,
  output logic               dispValid,
  output logic               wrapPulse
);

  typedef enum logic [1:0] {LOAD, SETUP, DWELL} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t             state;
  logic [3:0]         settle_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_last;
  logic               mode_lat;
  logic               at_last, outside, wrap_ok;

  // A zero dwell limit behaves like a limit of one.
  assign dwell_last = (dwellLimit == '0) ? '0 : dwellLimit - DWELL_W'(1);
  assign at_last    = (regAddr == lastAddr);
  assign outside    = (regAddr < firstAddr) || (regAddr > lastAddr);
  // An inverted window collapses to firstAddr and never reports a wrap.
  assign wrap_ok    = (firstAddr <= lastAddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      regAddr    <= '0;
      dispAddr   <= '0;
      dispData   <= '0;
      dispValid  <= 1'b0;
      wrapPulse  <= 1'b0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      mode_lat   <= 1'b0;
    end else begin
      wrapPulse <= 1'b0;
      case (state)
        LOAD: begin
          regAddr    <= mode ? firstAddr : manualAddr;
          mode_lat   <= mode;
          settle_cnt <= '0;
          state      <= SETUP;
        end
        SETUP: begin
          if (settle_cnt == SETTLE_LAST) begin
            dispData  <= regData;
            dispAddr  <= regAddr;
            dispValid <= 1'b1;
            dwell_cnt <= '0;
            state     <= DWELL;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        DWELL: begin
          if (!mode && manualAddr != regAddr) begin
            regAddr    <= manualAddr;
            mode_lat   <= mode;
            settle_cnt <= '0;
            state      <= SETUP;
          end else if (mode != mode_lat) begin
            state <= LOAD;
          end else if (pause) begin
            state <= DWELL;
          end else if (dwell_cnt == dwell_last) begin
            settle_cnt <= '0;
            state      <= SETUP;
            // Manual expiry just re-captures the same address.
            if (mode_lat) begin
              if (at_last || outside) begin
                regAddr   <= firstAddr;
                wrapPulse <= at_last && wrap_ok;
              end else begin
                regAddr <= regAddr + ADDR_W'(1);
              end
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_reg_scanner.sv
// Directed scenarios plus randomized traffic, every output compared each
// cycle against a countdown-based reference model.
module tb_sm_reg_scanner;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode, pause;
  logic [4:0]  manualAddr, firstAddr, lastAddr;
  logic [25:0] dwellLimit;
  logic [4:0]  regAddr, dispAddr;
  logic [31:0] regData, dispData;
  logic        dispValid, wrapPulse;

  logic [31:0] mem [32];
  assign regData = mem[regAddr];

  always #5 clk = ~clk;

  sm_reg_scanner #(.ADDR_W(5), .DATA_W(32), .DWELL_W(26), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pause(pause),
    .manualAddr(manualAddr), .firstAddr(firstAddr), .lastAddr(lastAddr),
    .dwellLimit(dwellLimit), .regAddr(regAddr), .regData(regData),
    .dispAddr(dispAddr), .dispData(dispData), .dispValid(dispValid),
    .wrapPulse(wrapPulse)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending load flag, cycles left until capture, dwell used.
  logic [4:0]  m_addr, m_daddr;
  logic [31:0] m_ddata;
  logic        m_dvalid, m_wrap, m_lat, m_need_load;
  int          m_settle_left, m_dwell;

  task automatic model_reset();
    m_addr = '0; m_daddr = '0; m_ddata = '0; m_dvalid = 1'b0; m_wrap = 1'b0;
    m_lat = 1'b0; m_need_load = 1'b1; m_settle_left = 0; m_dwell = 0;
  endtask

  task automatic model_step();
    int lim;
    lim = (dwellLimit == 0) ? 1 : int'(dwellLimit);
    m_wrap = 1'b0;
    if (m_need_load) begin
      m_addr = mode ? firstAddr : manualAddr;
      m_lat = mode; m_need_load = 1'b0; m_settle_left = SETTLE;
    end else if (m_settle_left > 0) begin
      m_settle_left--;
      if (m_settle_left == 0) begin
        m_ddata = mem[m_addr]; m_daddr = m_addr; m_dvalid = 1'b1; m_dwell = 0;
      end
    end else if (!mode && manualAddr != m_addr) begin
      m_addr = manualAddr; m_lat = mode; m_settle_left = SETTLE;
    end else if (mode != m_lat) begin
      m_need_load = 1'b1;
    end else if (!pause) begin
      if (m_dwell + 1 == lim) begin
        if (mode) begin
          m_wrap = (m_addr == lastAddr) && (firstAddr <= lastAddr);
          if (m_addr < firstAddr || m_addr >= lastAddr) m_addr = firstAddr;
          else m_addr = m_addr + 5'd1;
        end
        m_settle_left = SETTLE;
      end else begin
        m_dwell++;
      end
    end
  endtask

  task automatic check_outs();
    chk("regAddr", regAddr, m_addr);
    chk("dispAddr", dispAddr, m_daddr);
    chk("dispData", dispData, m_ddata);
    chk("dispValid", dispValid, m_dvalid);
    chk("wrapPulse", wrapPulse, m_wrap);
  endtask

  // Inputs are set at the negedge; the model steps, then one clock passes.
  task automatic cycle();
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int wraps, first_cap, found;

  initial begin
    rst_n = 1'b0; mode = 1'b1; pause = 1'b0;
    manualAddr = 5'd0; firstAddr = 5'd2; lastAddr = 5'd4; dwellLimit = 26'd3;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i * 16);
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_regAddr", regAddr, 0);
    chk("rst_dispValid", dispValid, 0);
    chk("rst_dispData", dispData, 0);
    check_outs();
    rst_n = 1'b1;

    // Auto window 2..4, 5 cycles per address, wrap on 4->2.
    wraps = 0;
    for (int i = 0; i < 40; i++) begin cycle(); wraps += int'(wrapPulse); end
    chk("auto_wraps", wraps, 2);

    // Manual refresh picks up changed register data.
    mode = 1'b0; manualAddr = 5'd7; dwellLimit = 26'd10; mem[7] = 32'h11;
    run(20);
    chk("man_data1", dispData, 32'h11);
    mem[7] = 32'h22;
    run(20);
    chk("man_data2", dispData, 32'h22);

    // Address change wins over pause.
    pause = 1'b1; manualAddr = 5'd9;
    run(10);
    chk("man_paused_addr", dispAddr, 9);
    pause = 1'b0;

    // Auto with a long pause in the middle of a dwell.
    mode = 1'b1; firstAddr = 5'd2; lastAddr = 5'd4; dwellLimit = 26'd3;
    run(12);
    pause = 1'b1; wraps = 0;
    for (int i = 0; i < 50; i++) begin cycle(); wraps += int'(wrapPulse); end
    chk("pause_wraps", wraps, 0);
    pause = 1'b0;
    run(20);

    // Inverted window with zero dwell: parks on firstAddr, never wraps.
    firstAddr = 5'd6; lastAddr = 5'd3; dwellLimit = 26'd0; wraps = 0;
    for (int i = 0; i < 30; i++) begin cycle(); wraps += int'(wrapPulse); end
    chk("inv_wraps", wraps, 0);
    chk("inv_addr", regAddr, 6);

    // Reset in the middle of SETUP, then time the first capture.
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_settle_left > 0 && !m_need_load) found = 1;
      else cycle();
    end
    chk("setup_reached", found, 1);
    rst_n = 1'b0; model_reset();
    #1 check_outs();
    cycle();
    rst_n = 1'b1;
    first_cap = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (first_cap == 0 && dispValid) first_cap = k;
    end
    chk("first_capture", first_cap, SETTLE + 1);

    // Randomized traffic, including async resets.
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0; model_reset();
        #1 check_outs();
      end
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 39) == 0) manualAddr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 59) == 0) begin
        firstAddr = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) lastAddr = 5'($urandom_range(0, 31));
        else lastAddr = firstAddr + 5'($urandom_range(0, 4));
        dwellLimit = 26'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 31)] = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
